// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for an N x N weight-stationary systolic array.
// Build option SYSTOLIC_CTRL_PERF_EN adds saturating busy-cycle / vector counters.
module systolic_ctrl #(
   parameter int N  = 16,
   parameter int DW = 8,
   parameter int IW = $clog2(N),
   parameter int MW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [MW-1:0]   cfg_num_vectors,
   input  logic [N-1:0]    cfg_col_enable,
   output logic            busy,
   output logic            done,
   output logic            w_rd_en,
   output logic [IW-1:0]   w_rd_addr,
   input  logic [N*DW-1:0] w_rd_data,
   output logic            in_rd_en,
   output logic [MW-1:0]   in_rd_addr,
   input  logic [N*DW-1:0] in_rd_data,
   output logic [N*DW-1:0] sa_weight,
   output logic [N*IW-1:0] sa_index,
   output logic [N-1:0]    sa_accept_w,
   output logic [N-1:0]    sa_col_enable,
   output logic [N*DW-1:0] sa_input,
   output logic [N-1:0]    sa_valid,
   output logic [N-1:0]    sa_switch,
   output logic [31:0]     perf_busy_cycles,
   output logic [31:0]     perf_vectors
);

   // state  | meaning
   // IDLE   | waiting for start
   // LOAD   | reading weight rows 0..N-1
   // DRAIN  | last weight row walking down to array row N-1
   // STREAM | reading input vectors 0..M-1
   // FLUSH  | row skew and partial sums draining out of the array

   localparam int TW = $clog2(3*N+3);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_STREAM, S_FLUSH} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [MW-1:0]   vec_rem_q, vec_rem_d;
   logic [MW-1:0]   num_vec_q, num_vec_d;
   logic [N-1:0]    sa_col_enable_q, sa_col_enable_d;
   logic            w_rd_en_q, w_rd_en_d;
   logic [IW-1:0]   w_rd_addr_q, w_rd_addr_d;
   logic            in_rd_en_q, in_rd_en_d;
   logic [MW-1:0]   in_rd_addr_q, in_rd_addr_d;
   logic            done_q, done_d;
   logic            sw_src_q, sw_src_d;

   always_comb begin
      state_d         = state_q;
      tmr_d           = tmr_q;
      vec_rem_d       = vec_rem_q;
      num_vec_d       = num_vec_q;
      sa_col_enable_d = sa_col_enable_q;
      w_rd_en_d       = w_rd_en_q;
      w_rd_addr_d     = w_rd_addr_q;
      in_rd_en_d      = in_rd_en_q;
      in_rd_addr_d    = in_rd_addr_q;
      done_d          = 1'b0;
      sw_src_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d         = S_LOAD;
               tmr_d           = TW'(N-1);
               num_vec_d       = cfg_num_vectors;
               sa_col_enable_d = cfg_col_enable;
               w_rd_en_d       = 1'b1;
               w_rd_addr_d     = '0;
            end
         end
         S_LOAD: begin
            if (tmr_q == '0) begin
               state_d     = S_DRAIN;
               tmr_d       = TW'(2*N-1);
               w_rd_en_d   = 1'b0;
               w_rd_addr_d = '0;
            end else begin
               tmr_d       = tmr_q - 1'b1;
               w_rd_addr_d = w_rd_addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (tmr_q == '0) begin
               // switch token enters the skew pipe one slot ahead of vector 0
               sw_src_d = 1'b1;
               if (num_vec_q != '0) begin
                  state_d      = S_STREAM;
                  in_rd_en_d   = 1'b1;
                  in_rd_addr_d = '0;
                  vec_rem_d    = num_vec_q - 1'b1;
               end else begin
                  state_d = S_FLUSH;
                  tmr_d   = TW'(3*N+1);
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_STREAM: begin
            if (vec_rem_q == '0) begin
               state_d      = S_FLUSH;
               tmr_d        = TW'(3*N+1);
               in_rd_en_d   = 1'b0;
               in_rd_addr_d = '0;
            end else begin
               vec_rem_d    = vec_rem_q - 1'b1;
               in_rd_addr_d = in_rd_addr_q + 1'b1;
            end
         end
         S_FLUSH: begin
            if (tmr_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         tmr_q           <= '0;
         vec_rem_q       <= '0;
         num_vec_q       <= '0;
         sa_col_enable_q <= '0;
         w_rd_en_q       <= 1'b0;
         w_rd_addr_q     <= '0;
         in_rd_en_q      <= 1'b0;
         in_rd_addr_q    <= '0;
         done_q          <= 1'b0;
         sw_src_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         tmr_q           <= tmr_d;
         vec_rem_q       <= vec_rem_d;
         num_vec_q       <= num_vec_d;
         sa_col_enable_q <= sa_col_enable_d;
         w_rd_en_q       <= w_rd_en_d;
         w_rd_addr_q     <= w_rd_addr_d;
         in_rd_en_q      <= in_rd_en_d;
         in_rd_addr_q    <= in_rd_addr_d;
         done_q          <= done_d;
         sw_src_q        <= sw_src_d;
      end
   end

   // north edge: buffer data arrives one cycle after the read, then is registered out
   logic            w_vld_q, w_vld_d;
   logic [IW-1:0]   w_idx_q, w_idx_d;
   logic            in_vld_q, in_vld_d;
   logic [N*DW-1:0] sa_weight_q, sa_weight_d;
   logic [N*IW-1:0] sa_index_q, sa_index_d;
   logic [N-1:0]    sa_accept_w_q, sa_accept_w_d;

   always_comb begin
      w_vld_d       = w_rd_en_q;
      w_idx_d       = w_rd_addr_q;
      in_vld_d      = in_rd_en_q;
      sa_accept_w_d = w_vld_q ? sa_col_enable_q : '0;
      sa_weight_d   = '0;
      sa_index_d    = '0;
      for (int c = 0; c < N; c++) begin
         if (sa_accept_w_d[c]) begin
            sa_weight_d[c*DW +: DW] = w_rd_data[c*DW +: DW];
            sa_index_d[c*IW +: IW]  = w_idx_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_vld_q       <= 1'b0;
         w_idx_q       <= '0;
         in_vld_q      <= 1'b0;
         sa_weight_q   <= '0;
         sa_index_q    <= '0;
         sa_accept_w_q <= '0;
      end else begin
         w_vld_q       <= w_vld_d;
         w_idx_q       <= w_idx_d;
         in_vld_q      <= in_vld_d;
         sa_weight_q   <= sa_weight_d;
         sa_index_q    <= sa_index_d;
         sa_accept_w_q <= sa_accept_w_d;
      end
   end

   // west edge: row r sees its element, valid and switch r cycles after row 0
   for (genvar r = 0; r < N; r++) begin : g_row
      logic [r:0]         vld_q, vld_d;
      logic [r:0]         sw_q, sw_d;
      logic [r:0][DW-1:0] dat_q, dat_d;

      always_comb begin
         vld_d    = vld_q;
         sw_d     = sw_q;
         dat_d    = dat_q;
         vld_d[0] = in_vld_q;
         sw_d[0]  = sw_src_q;
         dat_d[0] = in_vld_q ? in_rd_data[r*DW +: DW] : '0;
         for (int s = 1; s <= r; s++) begin
            vld_d[s] = vld_q[s-1];
            sw_d[s]  = sw_q[s-1];
            dat_d[s] = dat_q[s-1];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= '0;
            sw_q  <= '0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            sw_q  <= sw_d;
            dat_q <= dat_d;
         end
      end

      assign sa_valid[r]             = vld_q[r];
      assign sa_switch[r]            = sw_q[r];
      assign sa_input[r*DW +: DW]    = dat_q[r];
   end

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_vec_q, perf_vec_d;

   always_comb begin
      perf_busy_d = perf_busy_q;
      perf_vec_d  = perf_vec_q;
      if (busy && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
      if (in_rd_en_q && (perf_vec_q != '1)) perf_vec_d = perf_vec_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy_q <= '0;
         perf_vec_q  <= '0;
      end else begin
         perf_busy_q <= perf_busy_d;
         perf_vec_q  <= perf_vec_d;
      end
   end

   assign perf_busy_cycles = perf_busy_q;
   assign perf_vectors     = perf_vec_q;
`else
   assign perf_busy_cycles = '0;
   assign perf_vectors     = '0;
`endif

   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign w_rd_en       = w_rd_en_q;
   assign w_rd_addr     = w_rd_addr_q;
   assign in_rd_en      = in_rd_en_q;
   assign in_rd_addr    = in_rd_addr_q;
   assign sa_weight     = sa_weight_q;
   assign sa_index      = sa_index_q;
   assign sa_accept_w   = sa_accept_w_q;
   assign sa_col_enable = sa_col_enable_q;

endmodule
